irq_timer: RTL and testbench

IRQ_TIMER -- requirements
Module: irq_timer

---
 rtl/irq_timer_pkg.sv | 43 ++++
 rtl/irq_timer_if.sv | 23 ++
 rtl/irq_timer_prescale.sv | 35 +++
 rtl/irq_timer.sv | 172 +++++++++++++++++
 tb/tb_irq_timer.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_timer_pkg.sv
// irq_timer_pkg -- shared definitions for the irq_timer block.
//   Register offsets (word index taken from iomem_addr[4:2]), CTRL/STATUS
//   bit positions, register widths and a byte-lane merge helper.
package irq_timer_pkg;

  localparam int DATA_W     = 32;
  localparam int STRB_W     = DATA_W / 8;
  localparam int ADDR_LSB   = 2;
  localparam int ADDR_MSB   = 4;

  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_PRESCALE = 3'd1,
    REG_RELOAD   = 3'd2,
    REG_COUNT    = 3'd3,
    REG_STATUS   = 3'd4,
    REG_CAPTURE  = 3'd5
  } reg_off_e;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IE    = 2;
  localparam int CTRL_W     = 3;

  localparam int STAT_EXP   = 0;
  localparam int STAT_CAP   = 1;

  localparam int PRESCALE_W = 16;
  localparam int COUNT_W    = 32;

  // Merge new_v into old_v on the byte lanes selected by strb.
  function automatic logic [DATA_W-1:0] apply_wstrb(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_timer_if.sv
// irq_timer_if -- picosoc-style iomem bus between the SoC and irq_timer.
//   iomem_valid/wstrb/addr/wdata : master -> slave request (valid pre-decoded)
//   iomem_rdata/iomem_ready      : slave -> master completion
interface irq_timer_if;
  import irq_timer_pkg::*;

  logic              iomem_valid;
  logic [STRB_W-1:0] iomem_wstrb;
  logic [DATA_W-1:0] iomem_addr;
  logic [DATA_W-1:0] iomem_wdata;
  logic [DATA_W-1:0] iomem_rdata;
  logic              iomem_ready;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_rdata, iomem_ready
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_rdata, iomem_ready
  );
endinterface

// File: rtl/irq_timer_prescale.sv
// irq_timer_prescale -- prescaler for irq_timer.
//   clk, resetn : clock, asynchronous active-low reset
//   en          : count enable (CTRL.EN)
//   clr         : synchronous restart to 0 (takes priority over en)
//   limit       : PRESCALE value; counter runs 0..limit
//   tick        : one-cycle pulse while the counter sits at limit and en=1
module irq_timer_prescale
  import irq_timer_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] limit,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  // >= rather than == so that lowering PRESCALE below the current count
  // wraps immediately instead of running through the whole 16-bit range.
  assign tick = en && (cnt_q >= limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = tick ? '0 : cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/irq_timer.sv
// irq_timer -- prescaled down-counter with interrupt, on the picosoc iomem bus.
//   clk        : system clock (rising edge)
//   resetn     : asynchronous active-low reset
//   bus        : irq_timer_if.slave (iomem_valid/wstrb/addr/wdata/rdata/ready)
//   capture_in : async capture pin (only with IRQ_TIMER_CAPTURE_EN)
//   irq        : level interrupt = (EXP [| CAP]) & CTRL.IE, registered
// Registers by addr[4:2]: 0 CTRL, 1 PRESCALE, 2 RELOAD, 3 COUNT, 4 STATUS (W1C),
// 5 CAPTURE. Optional feature macro: IRQ_TIMER_CAPTURE_EN.
module irq_timer
  import irq_timer_pkg::*;
#(
  parameter logic [7:0] BASE_SEL = 8'h09  // SoC decode of addr[31:24]; informational
)
(
  input  logic        clk,
  input  logic        resetn,
  irq_timer_if.slave  bus,
`ifdef IRQ_TIMER_CAPTURE_EN
  input  logic        capture_in,
`endif
  output logic        irq
);

  logic                  ready_q, hold_q, irq_q, irq_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d, rd_val;
  logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [COUNT_W-1:0]    reload_q, reload_d, count_q, count_d;
  logic                  exp_q, exp_d;
  logic                  cap_q;
  logic [COUNT_W-1:0]    capture_q;
  logic                  irq_src;
  logic                  acc, wr, tick, expire, presc_clr, w1c_exp;
  logic [2:0]            reg_sel;
  logic [DATA_W-1:0]     ctrl_wval, prescale_wval, reload_wval, count_wval;
  logic                  unused_bits;

  assign reg_sel = bus.iomem_addr[ADDR_MSB:ADDR_LSB];

  // hold_q blocks a valid that was already high across reset so that only a
  // freshly presented request is answered; ready_q gates re-arming so a held
  // valid produces one pulse every other cycle.
  assign acc = bus.iomem_valid & ~ready_q & ~hold_q;
  assign wr  = acc & (|bus.iomem_wstrb);

  assign ctrl_wval     = apply_wstrb({{(DATA_W-CTRL_W){1'b0}}, ctrl_q}, bus.iomem_wdata, bus.iomem_wstrb);
  assign prescale_wval = apply_wstrb({{(DATA_W-PRESCALE_W){1'b0}}, prescale_q}, bus.iomem_wdata, bus.iomem_wstrb);
  assign reload_wval   = apply_wstrb(reload_q, bus.iomem_wdata, bus.iomem_wstrb);
  assign count_wval    = apply_wstrb(count_q, bus.iomem_wdata, bus.iomem_wstrb);

  irq_timer_prescale u_prescale (
    .clk    (clk),
    .resetn (resetn),
    .en     (ctrl_q[CTRL_EN]),
    .clr    (presc_clr),
    .limit  (prescale_q),
    .tick   (tick)
  );

  assign expire  = tick && (count_q == '0);
  assign w1c_exp = wr && (reg_sel == REG_STATUS) && bus.iomem_wstrb[0] && bus.iomem_wdata[STAT_EXP];
  // Set beats a same-cycle write-1-to-clear.
  assign exp_d   = (exp_q & ~w1c_exp) | expire;

  // Timer update first, then bus writes so a COUNT/CTRL write overrides it.
  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    reload_d   = reload_q;
    count_d    = count_q;
    presc_clr  = 1'b0;
    if (tick) begin
      if (count_q != '0)          count_d = count_q - 32'd1;
      else if (ctrl_q[CTRL_AUTO]) count_d = reload_q;
      else                        ctrl_d[CTRL_EN] = 1'b0;
    end
    if (wr) begin
      case (reg_sel)
        REG_CTRL: begin
          ctrl_d    = ctrl_wval[CTRL_W-1:0];
          presc_clr = ctrl_wval[CTRL_EN] != ctrl_q[CTRL_EN];
        end
        REG_PRESCALE: prescale_d = prescale_wval[PRESCALE_W-1:0];
        REG_RELOAD:   reload_d   = reload_wval;
        REG_COUNT:    count_d    = count_wval;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_CTRL:     rd_val[CTRL_W-1:0]     = ctrl_q;
      REG_PRESCALE: rd_val[PRESCALE_W-1:0] = prescale_q;
      REG_RELOAD:   rd_val                 = reload_q;
      REG_COUNT:    rd_val                 = count_q;
      REG_STATUS: begin
        rd_val[STAT_EXP] = exp_q;
        rd_val[STAT_CAP] = cap_q;
      end
      REG_CAPTURE:  rd_val                 = capture_q;
      default:      rd_val                 = '0;
    endcase
  end

  assign rdata_d = acc ? rd_val : '0;
  assign irq_d   = irq_src & ctrl_d[CTRL_IE];

`ifdef IRQ_TIMER_CAPTURE_EN
  // [0],[1] synchronise capture_in; [2] holds the previous synced level.
  logic [2:0]         cap_sync_q;
  logic               cap_edge, cap_d, w1c_cap;
  logic [COUNT_W-1:0] capture_d;

  assign cap_edge  = cap_sync_q[1] & ~cap_sync_q[2];
  assign w1c_cap   = wr && (reg_sel == REG_STATUS) && bus.iomem_wstrb[0] && bus.iomem_wdata[STAT_CAP];
  assign cap_d     = (cap_q & ~w1c_cap) | cap_edge;
  assign capture_d = cap_edge ? count_q : capture_q;
  assign irq_src   = exp_d | cap_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cap_sync_q <= '0;
      cap_q      <= 1'b0;
      capture_q  <= '0;
    end else begin
      cap_sync_q <= {cap_sync_q[1:0], capture_in};
      cap_q      <= cap_d;
      capture_q  <= capture_d;
    end
  end
`else
  assign cap_q     = 1'b0;
  assign capture_q = '0;
  assign irq_src   = exp_d;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q    <= 1'b0;
      hold_q     <= 1'b1;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
      ctrl_q     <= '0;
      prescale_q <= '0;
      reload_q   <= '0;
      count_q    <= '0;
      exp_q      <= 1'b0;
    end else begin
      ready_q    <= acc;
      hold_q     <= hold_q & bus.iomem_valid;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      exp_q      <= exp_d;
    end
  end

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign irq             = irq_q;

  // Address bits outside [4:2], BASE_SEL and the unused merge bits are
  // intentionally ignored.
  assign unused_bits = ^{bus.iomem_addr[DATA_W-1:ADDR_MSB+1], bus.iomem_addr[ADDR_LSB-1:0],
                         BASE_SEL, ctrl_wval[DATA_W-1:CTRL_W], prescale_wval[DATA_W-1:PRESCALE_W]};

endmodule

// File: tb/tb_irq_timer.sv
// tb_irq_timer -- self-checking bench for irq_timer (iomem bus, timer, IRQ).
// Expected read values go into a scoreboard queue before each read and are
// popped when the completed transfer returns data.
module tb_irq_timer;

  logic clk = 1'b0;
  logic resetn;
  logic irq;
`ifdef IRQ_TIMER_CAPTURE_EN
  logic capture_in;
`endif

  irq_timer_if bus_if();

  irq_timer #(.BASE_SEL(8'h09)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus_if),
`ifdef IRQ_TIMER_CAPTURE_EN
    .capture_in (capture_in),
`endif
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ready_miss = 0;
  logic [31:0] exp_fifo[$];

  task automatic bus_xfer(input logic [2:0] off, input logic [3:0] strb,
                          input logic [31:0] wdata, output logic [31:0] rdata);
    @(negedge clk);
    bus_if.iomem_valid = 1'b1;
    bus_if.iomem_addr  = {27'd0, off, 2'b00};
    bus_if.iomem_wstrb = strb;
    bus_if.iomem_wdata = wdata;
    @(posedge clk);
    #1;
    if (bus_if.iomem_ready !== 1'b1) ready_miss++;
    rdata = bus_if.iomem_rdata;
    @(negedge clk);
    bus_if.iomem_valid = 1'b0;
    bus_if.iomem_wstrb = 4'h0;
    $display("bus off=%0d wstrb=%h wdata=%h rdata=%h", off, strb, wdata, rdata);
  endtask

  task automatic wr(input logic [2:0] off, input logic [3:0] strb, input logic [31:0] data);
    logic [31:0] dummy;
    bus_xfer(off, strb, data, dummy);
  endtask

  task automatic rd(input logic [2:0] off, output logic [31:0] data);
    bus_xfer(off, 4'h0, 32'h0, data);
  endtask

  task automatic test_reset();
    logic [31:0] got, e;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++;
    if (bus_if.iomem_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", bus_if.iomem_ready); end
    for (int i = 0; i < 8; i++) exp_fifo.push_back(32'h0);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), got);
      e = exp_fifo.pop_front();
      checks++;
      if (got !== e) begin failures++; $display("FAIL reset_read off=%0d: got %h expected %h", i, got, e); end
    end
  endtask

  task automatic test_bytelane();
    logic [31:0] got, e;
    wr(3'd2, 4'b0010, 32'hAABBCCDD);
    exp_fifo.push_back(32'h0000CC00);
    rd(3'd2, got);
    e = exp_fifo.pop_front();
    checks++;
    if (got !== e) begin failures++; $display("FAIL bytelane_reload: got %h expected %h", got, e); end
  endtask

  task automatic test_readback();
    logic [31:0] got, e;
    logic [2:0]  offs [5];
    logic [31:0] wds  [5];
    logic [31:0] exps [5];
    offs = '{3'd1, 3'd6, 3'd5, 3'd0, 3'd4};
    wds  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFFFFF8, 32'h00000003};
    exps = '{32'h0000FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      wr(offs[i], 4'hF, wds[i]);
      exp_fifo.push_back(exps[i]);
      rd(offs[i], got);
      e = exp_fifo.pop_front();
      checks++;
      if (got !== e) begin failures++; $display("FAIL readback off=%0d: got %h expected %h", offs[i], got, e); end
    end
    wr(3'd1, 4'hF, 32'h0);
  endtask

  task automatic test_ready();
    logic exp_pat [4];
    exp_pat = '{1'b1, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    bus_if.iomem_valid = 1'b1;
    bus_if.iomem_addr  = 32'h0;
    bus_if.iomem_wstrb = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus_if.iomem_ready !== exp_pat[i]) begin
        failures++; $display("FAIL ready_pattern cycle=%0d: got %b expected %b", i, bus_if.iomem_ready, exp_pat[i]);
      end
    end
    @(negedge clk);
    bus_if.iomem_valid = 1'b0;
  endtask

  task automatic test_oneshot();
    logic [31:0] got, e;
    int n;
    wr(3'd4, 4'hF, 32'h3);
    wr(3'd1, 4'hF, 32'd3);
    wr(3'd3, 4'hF, 32'd2);
    exp_fifo.push_back(32'd12);
    wr(3'd0, 4'hF, 32'h5);
    n = 0;
    while (irq !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    e = exp_fifo.pop_front();
    checks++;
    if (n < int'(e) - 1 || n > int'(e) + 1) begin failures++; $display("FAIL oneshot_latency: got %0d cycles expected %0d", n, e); end
    exp_fifo.push_back(32'h4);
    exp_fifo.push_back(32'h0);
    exp_fifo.push_back(32'h1);
    rd(3'd0, got); e = exp_fifo.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL oneshot_ctrl: got %h expected %h", got, e); end
    rd(3'd3, got); e = exp_fifo.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL oneshot_count: got %h expected %h", got, e); end
    rd(3'd4, got); e = exp_fifo.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL oneshot_status: got %h expected %h", got, e); end
    wr(3'd4, 4'hF, 32'h1);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL oneshot_w1c_irq: got %b expected 0", irq); end
    wr(3'd0, 4'hF, 32'h0);
  endtask

  task automatic test_auto();
    logic [31:0] got, e;
    int n;
    wr(3'd1, 4'hF, 32'd0);
    wr(3'd2, 4'hF, 32'd4);
    wr(3'd3, 4'hF, 32'd0);
    wr(3'd0, 4'hF, 32'h7);          // takes effect on edge W; expiries W+1, W+6, W+11
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL auto_first_tick: got %b expected 1", irq); end
    wr(3'd4, 4'hF, 32'h1);          // W1C at W+3
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL auto_w1c_drop: got %b expected 0", irq); end
    exp_fifo.push_back(32'd3);
    n = 0;
    while (irq !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    e = exp_fifo.pop_front();
    checks++;
    if (n !== int'(e)) begin failures++; $display("FAIL auto_period: got %0d expected %0d", n, e); end
    repeat (3) @(negedge clk);
    wr(3'd4, 4'hF, 32'h1);          // W1C coincident with expiry at W+11
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL set_over_clear_irq: got %b expected 1", irq); end
    exp_fifo.push_back(32'h1);
    rd(3'd4, got);
    e = exp_fifo.pop_front();
    checks++;
    if (got !== e) begin failures++; $display("FAIL set_over_clear_status: got %h expected %h", got, e); end
    wr(3'd0, 4'hF, 32'h0);
    wr(3'd4, 4'hF, 32'h3);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL auto_stop_irq: got %b expected 0", irq); end
  endtask

  task automatic test_count_priority();
    logic [31:0] got, e;
    wr(3'd3, 4'hF, 32'd50);
    wr(3'd0, 4'hF, 32'h1);
    wr(3'd3, 4'hF, 32'd100);        // written on W, one decrement at W+1
    exp_fifo.push_back(32'd99);
    rd(3'd3, got);                  // data captured on W+2
    e = exp_fifo.pop_front();
    checks++;
    if (got !== e) begin failures++; $display("FAIL count_write_priority: got %0d expected %0d", got, e); end
    wr(3'd0, 4'hF, 32'h0);
  endtask

`ifdef IRQ_TIMER_CAPTURE_EN
  task automatic test_capture();
    logic [31:0] got, e;
    int n;
    wr(3'd4, 4'hF, 32'h3);
    wr(3'd1, 4'hF, 32'h0000FFFF);
    wr(3'd3, 4'hF, 32'h10);
    wr(3'd0, 4'hF, 32'h5);
    exp_fifo.push_back(32'd3);
    @(negedge clk);
    capture_in = 1'b1;
    n = 0;
    while (irq !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    e = exp_fifo.pop_front();
    checks++;
    if (n !== int'(e)) begin failures++; $display("FAIL capture_latency: got %0d expected %0d", n, e); end
    exp_fifo.push_back(32'h10);
    exp_fifo.push_back(32'h2);
    rd(3'd5, got); e = exp_fifo.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL capture_value: got %h expected %h", got, e); end
    rd(3'd4, got); e = exp_fifo.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL capture_status: got %h expected %h", got, e); end
    capture_in = 1'b0;
    wr(3'd0, 4'hF, 32'h0);
    wr(3'd4, 4'hF, 32'h3);
    wr(3'd1, 4'hF, 32'h0);
  endtask
`endif

  task automatic test_mid_reset();
    logic [31:0] got, e;
    wr(3'd1, 4'hF, 32'd0);
    wr(3'd2, 4'hF, 32'h1234);
    wr(3'd3, 4'hF, 32'd0);
    wr(3'd0, 4'hF, 32'h7);
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL midreset_pre_irq: got %b expected 1", irq); end
    @(negedge clk);
    bus_if.iomem_valid = 1'b1;
    bus_if.iomem_addr  = 32'hC;
    bus_if.iomem_wstrb = 4'h0;
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL midreset_async_irq: got %b expected 0", irq); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus_if.iomem_ready !== 1'b0) begin failures++; $display("FAIL midreset_ready cycle=%0d: got %b expected 0", i, bus_if.iomem_ready); end
    end
    @(negedge clk);
    bus_if.iomem_valid = 1'b0;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL midreset_irq: got %b expected 0", irq); end
    for (int i = 0; i < 8; i++) exp_fifo.push_back(32'h0);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), got);
      e = exp_fifo.pop_front();
      checks++;
      if (got !== e) begin failures++; $display("FAIL midreset_read off=%0d: got %h expected %h", i, got, e); end
    end
  endtask

  task automatic test_bus_health();
    checks++;
    if (ready_miss !== 0) begin failures++; $display("FAIL ready_missing: got %0d missed pulses expected 0", ready_miss); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn             = 1'b0;
    bus_if.iomem_valid = 1'b0;
    bus_if.iomem_wstrb = 4'h0;
    bus_if.iomem_addr  = 32'h0;
    bus_if.iomem_wdata = 32'h0;
`ifdef IRQ_TIMER_CAPTURE_EN
    capture_in = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    test_reset();
    test_bytelane();
    test_readback();
    test_ready();
    test_oneshot();
    test_auto();
    test_count_priority();
`ifdef IRQ_TIMER_CAPTURE_EN
    test_capture();
`endif
    test_mid_reset();
    test_bus_health();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
